// File: rtl/test_pattern_checker_if.sv
// Video tap bus between the DVI test pattern generator (master) and a receive-side checker (slave).
// Counters and video_active lead the RGB by the generator's pipeline delay.
interface test_pattern_checker_if;
  logic [9:0] h_count;
  logic [9:0] v_count;
  logic       video_active;
  logic [7:0] red;
  logic [7:0] green;
  logic [7:0] blue;

  modport master (output h_count, v_count, video_active, red, green, blue);
  modport slave  (input  h_count, v_count, video_active, red, green, blue);
endinterface

// File: rtl/test_pattern_checker.sv
// Receive-side checker for the DVI test pattern generator: recomputes the selected pattern and
// compares it with the received RGB over N whole frames. Define CHECKER_CRC_EN for a per-frame CRC-16.
module test_pattern_checker #(
  parameter int unsigned PIPE_DELAY = 1,
  parameter int unsigned ERR_W      = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  test_pattern_checker_if.slave  vid,
  input  logic                   start_i,
  input  logic [1:0]             pattern_sel_i,
  input  logic [7:0]             num_frames_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   pass_o,
  output logic [ERR_W-1:0]       error_count_o,
  output logic [9:0]             first_err_x_o,
  output logic [9:0]             first_err_y_o,
  output logic [7:0]             frames_checked_o
`ifdef CHECKER_CRC_EN
  ,
  output logic [15:0]            frame_crc_o,
  output logic                   crc_valid_o
`endif
);

  localparam int unsigned CNT_W = 10;
  localparam int unsigned FRM_W = 8;
  localparam int unsigned RGB_W = 24;

  typedef enum logic [1:0] {IDLE, SYNC, CHECK, DONE} state_t;
  typedef struct packed {
    logic             active;
    logic [CNT_W-1:0] h;
    logic [CNT_W-1:0] v;
  } tap_t;

  localparam int unsigned   TAP_W   = $bits(tap_t);
  localparam int unsigned   PIPE_W  = PIPE_DELAY * TAP_W;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  tap_t              tap_in, tap_dn;
  logic [PIPE_W-1:0] pipe_q;
  logic [RGB_W-1:0]  rx_rgb, exp_rgb;
  logic [2:0]        bar_idx;
  logic              frame_start, mismatch, check_en;

  state_t            state_q, state_d;
  logic [1:0]        sel_q, sel_d;
  logic [FRM_W-1:0]  num_q, num_d, frames_q, frames_d, frames_inc;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [CNT_W-1:0]  fx_q, fx_d, fy_q, fy_d;
  logic              pass_q, pass_d, busy_q, done_q;

  assign tap_in = {vid.video_active, vid.h_count, vid.v_count};
  assign rx_rgb = {vid.red, vid.green, vid.blue};

  // Delay the timing tap so it lines up with the RGB it describes
  if (PIPE_DELAY > 1) begin : g_deep
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pipe_q <= '0;
      else        pipe_q <= {pipe_q[PIPE_W-TAP_W-1:0], tap_in};
    end
  end else begin : g_single
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pipe_q <= '0;
      else        pipe_q <= tap_in;
    end
  end

  assign tap_dn      = pipe_q[PIPE_W-1 -: TAP_W];
  assign bar_idx     = 3'(tap_dn.h / 10'd80);
  assign frame_start = tap_dn.active && (tap_dn.h == '0) && (tap_dn.v == '0);
  assign frames_inc  = frames_q + FRM_W'(1);

  always_comb begin : expected_pixel
    exp_rgb = '0;
    if (tap_dn.active) begin
      case (sel_q)
        2'b00: begin
          case (bar_idx)
            3'd0:    exp_rgb = 24'hFFFFFF;
            3'd1:    exp_rgb = 24'hFFFF00;
            3'd2:    exp_rgb = 24'h00FFFF;
            3'd3:    exp_rgb = 24'h00FF00;
            3'd4:    exp_rgb = 24'hFF00FF;
            3'd5:    exp_rgb = 24'hFF0000;
            3'd6:    exp_rgb = 24'h0000FF;
            default: exp_rgb = 24'h000000;
          endcase
        end
        2'b01:   exp_rgb = (tap_dn.h[5] ^ tap_dn.v[5]) ? 24'hFFFFFF : 24'h000000;
        2'b10:   exp_rgb = ((tap_dn.h[6:0] < 7'd2) || (tap_dn.v[5:0] < 6'd2)) ? 24'hFFFFFF
                                                                            : 24'h004080;
        default: exp_rgb = 24'h808080;
      endcase
    end
  end

  assign mismatch = (rx_rgb != exp_rgb);

  always_comb begin : fsm_next
    state_d  = state_q;
    sel_d    = sel_q;
    num_d    = num_q;
    err_d    = err_q;
    fx_d     = fx_q;
    fy_d     = fy_q;
    frames_d = frames_q;
    pass_d   = pass_q;
    check_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d  = SYNC;
          sel_d    = pattern_sel_i;
          num_d    = (num_frames_i == '0) ? FRM_W'(1) : num_frames_i;
          err_d    = '0;
          fx_d     = '0;
          fy_d     = '0;
          frames_d = '0;
          pass_d   = 1'b0;
        end
      end
      SYNC: begin
        if (frame_start) begin
          state_d  = CHECK;
          check_en = 1'b1;
        end
      end
      CHECK: begin
        if (frame_start) frames_d = frames_inc;
        // The pixel that closes the last frame belongs to the next frame, so it is not compared
        if (frame_start && (frames_inc == num_q)) begin
          state_d = DONE;
          pass_d  = (err_q == '0);
        end else begin
          check_en = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (check_en && mismatch) begin
      if (err_q == '0) begin
        fx_d = tap_dn.h;
        fy_d = tap_dn.v;
      end
      if (err_q != ERR_MAX) err_d = err_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin : fsm_reg
    if (!rst_n) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      num_q    <= '0;
      err_q    <= '0;
      fx_q     <= '0;
      fy_q     <= '0;
      frames_q <= '0;
      pass_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      num_q    <= num_d;
      err_q    <= err_d;
      fx_q     <= fx_d;
      fy_q     <= fy_d;
      frames_q <= frames_d;
      pass_q   <= pass_d;
      busy_q   <= (state_d == SYNC) || (state_d == CHECK);
      done_q   <= (state_d == DONE);
    end
  end

  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign pass_o           = pass_q;
  assign error_count_o    = err_q;
  assign first_err_x_o    = fx_q;
  assign first_err_y_o    = fy_q;
  assign frames_checked_o = frames_q;

`ifdef CHECKER_CRC_EN
  logic [15:0] crc_q, crc_d, fcrc_q, fcrc_d;
  logic        crc_valid_q, crc_valid_d;

  // CRC-16-CCITT over one 24-bit pixel, MSB first
  function automatic logic [15:0] crc16_px(input logic [15:0] crc_in, input logic [RGB_W-1:0] px);
    logic [15:0]      c;
    logic [RGB_W-1:0] d;
    c = crc_in;
    d = px;
    for (int unsigned i = 0; i < RGB_W; i++) begin
      c = (c[15] ^ d[RGB_W-1]) ? ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
      d = {d[RGB_W-2:0], 1'b0};
    end
    return c;
  endfunction

  always_comb begin : crc_next
    crc_d       = crc_q;
    fcrc_d      = fcrc_q;
    crc_valid_d = 1'b0;
    if (frame_start && ((state_q == SYNC) || (state_q == CHECK))) begin
      crc_d = crc16_px(16'hFFFF, rx_rgb);
    end else if ((state_q == CHECK) && tap_dn.active) begin
      crc_d = crc16_px(crc_q, rx_rgb);
    end
    if ((state_q == CHECK) && frame_start) begin
      fcrc_d      = crc_q;
      crc_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin : crc_reg
    if (!rst_n) begin
      crc_q       <= 16'hFFFF;
      fcrc_q      <= '0;
      crc_valid_q <= 1'b0;
    end else begin
      crc_q       <= crc_d;
      fcrc_q      <= fcrc_d;
      crc_valid_q <= crc_valid_d;
    end
  end

  assign frame_crc_o = fcrc_q;
  assign crc_valid_o = crc_valid_q;
`endif

endmodule

// File: tb/tb_test_pattern_checker.sv
// Directed bench for test_pattern_checker: drives a reduced-size frame whose counters visit
// selected coordinates, with the RGB delayed PIPE_DELAY cycles behind the counters.
module tb_test_pattern_checker;
  localparam int PD        = 2;
  localparam int EW        = 8;
  localparam int NH        = 14;
  localparam int NV        = 8;
  localparam int FR        = NH * NV;
  localparam int START_IDX = 50;
  localparam int BUSY_EXP2 = 3 * FR - START_IDX + PD;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic          start_i;
  logic [1:0]    pattern_sel_i;
  logic [7:0]    num_frames_i;
  logic          busy_o, done_o, pass_o;
  logic [EW-1:0] error_count_o;
  logic [9:0]    first_err_x_o, first_err_y_o;
  logic [7:0]    frames_checked_o;
`ifdef CHECKER_CRC_EN
  logic [15:0]   frame_crc_o;
  logic          crc_valid_o;
  int            crc_cnt;
  logic [15:0]   crc_seen [4];
`endif

  test_pattern_checker_if vif ();

  test_pattern_checker #(.PIPE_DELAY(PD), .ERR_W(EW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .vid              (vif),
    .start_i          (start_i),
    .pattern_sel_i    (pattern_sel_i),
    .num_frames_i     (num_frames_i),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .pass_o           (pass_o),
    .error_count_o    (error_count_o),
    .first_err_x_o    (first_err_x_o),
    .first_err_y_o    (first_err_y_o),
    .frames_checked_o (frames_checked_o)
`ifdef CHECKER_CRC_EN
    ,
    .frame_crc_o      (frame_crc_o),
    .crc_valid_o      (crc_valid_o)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int hl [NH] = '{0, 1, 2, 40, 100, 160, 240, 320, 400, 480, 560, 639, 640, 700};
  int vl [NV] = '{0, 1, 10, 33, 70, 479, 480, 500};
  int hi = 0, vi = 0, cur_idx = 0;
  int busy_cnt, done_cnt, overlap_cnt;
  logic [1:0]  gen_sel;
  bit          corrupt_all, inj_en;
  int          inj_h, inj_v;
  logic [23:0] inj_val;
  logic [23:0] pix_pipe [PD];

  function automatic logic [23:0] model_pix(input logic [1:0] sel, input int h, input int v);
    if (h >= 640 || v >= 480) return 24'h000000;
    case (sel)
      2'b00: begin
        if (h < 80)  return 24'hFFFFFF;
        if (h < 160) return 24'hFFFF00;
        if (h < 240) return 24'h00FFFF;
        if (h < 320) return 24'h00FF00;
        if (h < 400) return 24'hFF00FF;
        if (h < 480) return 24'hFF0000;
        if (h < 560) return 24'h0000FF;
        return 24'h000000;
      end
      2'b01:   return (((h / 32) % 2) != ((v / 32) % 2)) ? 24'hFFFFFF : 24'h000000;
      2'b10:   return ((h % 128) < 2 || (v % 64) < 2) ? 24'hFFFFFF : 24'h004080;
      default: return 24'h808080;
    endcase
  endfunction

  function automatic logic [15:0] crc_px(input logic [15:0] c_in, input logic [23:0] d_in);
    logic [15:0] c;
    logic [23:0] d;
    c = c_in;
    d = d_in;
    repeat (24) begin
      if (c[15] ^ d[23]) c = (c << 1) ^ 16'h1021;
      else               c = c << 1;
      d = d << 1;
    end
    return c;
  endfunction

  // One pixel clock: sample outputs, then drive the next counters and the delayed RGB
  task automatic tick();
    int h, v;
    logic [23:0] px;
    @(negedge clk);
    if (busy_o === 1'b1) busy_cnt++;
    if (done_o === 1'b1) done_cnt++;
    if (busy_o === 1'b1 && done_o === 1'b1) overlap_cnt++;
`ifdef CHECKER_CRC_EN
    if (crc_valid_o === 1'b1) begin
      if (crc_cnt < 4) crc_seen[crc_cnt] = frame_crc_o;
      crc_cnt++;
    end
`endif
    h  = hl[hi];
    v  = vl[vi];
    px = model_pix(gen_sel, h, v);
    if (corrupt_all) px = ~px;
    if (inj_en && h == inj_h && v == inj_v) px = inj_val;
    {vif.red, vif.green, vif.blue} = pix_pipe[PD-1];
    for (int i = PD - 1; i > 0; i--) pix_pipe[i] = pix_pipe[i-1];
    pix_pipe[0] = px;
    vif.h_count      = 10'(h);
    vif.v_count      = 10'(v);
    vif.video_active = (h < 640 && v < 480);
    cur_idx = vi * NH + hi;
    if (hi == NH - 1) begin
      hi = 0;
      vi = (vi == NV - 1) ? 0 : vi + 1;
    end else begin
      hi++;
    end
  endtask

  task automatic launch(input logic [1:0] sel, input logic [7:0] num);
    int guard;
    guard = 0;
    while (cur_idx != START_IDX && guard < 2 * FR) begin
      tick();
      guard++;
    end
    pattern_sel_i = sel;
    num_frames_i  = num;
    start_i       = 1'b1;
    busy_cnt      = 0;
    done_cnt      = 0;
    overlap_cnt   = 0;
`ifdef CHECKER_CRC_EN
    crc_cnt       = 0;
`endif
    tick();
    start_i = 1'b0;
  endtask

  task automatic run_until_done(input int budget, output bit got);
    got = 1'b0;
    for (int c = 0; c < budget && !got; c++) begin
      tick();
      if (done_o === 1'b1) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0b want=0", busy_o); end
    checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL rst_done got=%0b want=0", done_o); end
    checks++; if (pass_o !== 1'b0) begin failures++; $display("FAIL rst_pass got=%0b want=0", pass_o); end
    checks++; if (error_count_o !== '0) begin failures++; $display("FAIL rst_err got=%0h want=0", error_count_o); end
    checks++; if ({first_err_x_o, first_err_y_o} !== 20'h0) begin failures++; $display("FAIL rst_first got=%0d,%0d want=0,0", first_err_x_o, first_err_y_o); end
    checks++; if (frames_checked_o !== 8'd0) begin failures++; $display("FAIL rst_frames got=%0d want=0", frames_checked_o); end
`ifdef CHECKER_CRC_EN
    checks++; if ({frame_crc_o, crc_valid_o} !== 17'h0) begin failures++; $display("FAIL rst_crc got=%0h/%0b want=0/0", frame_crc_o, crc_valid_o); end
`endif
    rst_n = 1'b1;
    repeat (4) tick();
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL idle_busy got=%0b want=0", busy_o); end
  endtask

  task automatic test_bars_pass();
    bit got;
    gen_sel = 2'b00;
    launch(2'b00, 8'd2);
    run_until_done(4 * FR, got);
    checks++; if (!got) begin failures++; $display("FAIL bars_done got=0 want=1"); end
    checks++; if (pass_o !== 1'b1) begin failures++; $display("FAIL bars_pass got=%0b want=1", pass_o); end
    checks++; if (error_count_o !== EW'(0)) begin failures++; $display("FAIL bars_err got=%0d want=0", error_count_o); end
    checks++; if (frames_checked_o !== 8'd2) begin failures++; $display("FAIL bars_frames got=%0d want=2", frames_checked_o); end
    repeat (3) tick();
    checks++; if (busy_cnt != BUSY_EXP2) begin failures++; $display("FAIL bars_busy_len got=%0d want=%0d", busy_cnt, BUSY_EXP2); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL bars_done_pulse got=%0d want=1", done_cnt); end
    checks++; if (overlap_cnt != 0) begin failures++; $display("FAIL bars_busy_done got=%0d want=0", overlap_cnt); end
  endtask

  task automatic test_single_error();
    bit got;
    gen_sel = 2'b00;
    inj_en = 1'b1; inj_h = 100; inj_v = 10; inj_val = 24'h00FF00;
    launch(2'b00, 8'd0);
    run_until_done(4 * FR, got);
    inj_en = 1'b0;
    checks++; if (!got) begin failures++; $display("FAIL one_done got=0 want=1"); end
    checks++; if (error_count_o !== EW'(1)) begin failures++; $display("FAIL one_err got=%0d want=1", error_count_o); end
    checks++; if (first_err_x_o !== 10'd100 || first_err_y_o !== 10'd10) begin failures++; $display("FAIL one_first got=%0d,%0d want=100,10", first_err_x_o, first_err_y_o); end
    checks++; if (pass_o !== 1'b0) begin failures++; $display("FAIL one_pass got=%0b want=0", pass_o); end
    checks++; if (frames_checked_o !== 8'd1) begin failures++; $display("FAIL num0_frames got=%0d want=1", frames_checked_o); end
  endtask

  task automatic test_blank_error();
    bit got;
    gen_sel = 2'b00;
    inj_en = 1'b1; inj_h = 700; inj_v = 10; inj_val = 24'h010101;
    launch(2'b00, 8'd1);
    run_until_done(4 * FR, got);
    inj_en = 1'b0;
    checks++; if (!got) begin failures++; $display("FAIL blank_done got=0 want=1"); end
    checks++; if (error_count_o !== EW'(1)) begin failures++; $display("FAIL blank_err got=%0d want=1", error_count_o); end
    checks++; if (first_err_x_o !== 10'd700 || first_err_y_o !== 10'd10) begin failures++; $display("FAIL blank_first got=%0d,%0d want=700,10", first_err_x_o, first_err_y_o); end
  endtask

  task automatic test_saturate();
    bit got;
    gen_sel = 2'b11;
    corrupt_all = 1'b1;
    launch(2'b11, 8'd3);
    run_until_done(6 * FR, got);
    corrupt_all = 1'b0;
    checks++; if (!got) begin failures++; $display("FAIL sat_done got=0 want=1"); end
    checks++; if (error_count_o !== EW'(255)) begin failures++; $display("FAIL sat_err got=%0d want=255", error_count_o); end
    checks++; if (first_err_x_o !== 10'd0 || first_err_y_o !== 10'd0) begin failures++; $display("FAIL sat_first got=%0d,%0d want=0,0", first_err_x_o, first_err_y_o); end
    checks++; if (frames_checked_o !== 8'd3) begin failures++; $display("FAIL sat_frames got=%0d want=3", frames_checked_o); end
  endtask

  task automatic test_patterns();
    bit got;
    logic [1:0] sels [3] = '{2'b01, 2'b10, 2'b11};
    for (int k = 0; k < 3; k++) begin
      gen_sel = sels[k];
      launch(sels[k], 8'd1);
      run_until_done(4 * FR, got);
      checks++; if (!got) begin failures++; $display("FAIL pat%0d_done got=0 want=1", sels[k]); end
      checks++; if (pass_o !== 1'b1) begin failures++; $display("FAIL pat%0d_pass got=%0b want=1", sels[k], pass_o); end
      checks++; if (error_count_o !== EW'(0)) begin failures++; $display("FAIL pat%0d_err got=%0d want=0", sels[k], error_count_o); end
    end
  endtask

  task automatic test_wrong_pattern();
    bit got;
    int exp_cnt, ex, ey;
    exp_cnt = 0; ex = 0; ey = 0;
    for (int y = 0; y < NV; y++) begin
      for (int x = 0; x < NH; x++) begin
        if (model_pix(2'b01, hl[x], vl[y]) != model_pix(2'b10, hl[x], vl[y])) begin
          if (exp_cnt == 0) begin ex = hl[x]; ey = vl[y]; end
          exp_cnt++;
        end
      end
    end
    gen_sel = 2'b01;
    launch(2'b10, 8'd1);
    run_until_done(4 * FR, got);
    checks++; if (!got) begin failures++; $display("FAIL wrong_done got=0 want=1"); end
    checks++; if (error_count_o !== EW'(exp_cnt)) begin failures++; $display("FAIL wrong_err got=%0d want=%0d", error_count_o, exp_cnt); end
    checks++; if (first_err_x_o !== 10'(ex) || first_err_y_o !== 10'(ey)) begin failures++; $display("FAIL wrong_first got=%0d,%0d want=%0d,%0d", first_err_x_o, first_err_y_o, ex, ey); end
    checks++; if (pass_o !== 1'b0) begin failures++; $display("FAIL wrong_pass got=%0b want=0", pass_o); end
  endtask

  task automatic test_sel_latch();
    bit got;
    int busy_before;
    gen_sel = 2'b01;
    launch(2'b01, 8'd2);
    repeat (20) tick();
    pattern_sel_i = 2'b10;
    repeat (130) tick();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    run_until_done(4 * FR, got);
    checks++; if (!got) begin failures++; $display("FAIL latch_done got=0 want=1"); end
    checks++; if (pass_o !== 1'b1) begin failures++; $display("FAIL latch_pass got=%0b want=1", pass_o); end
    checks++; if (frames_checked_o !== 8'd2) begin failures++; $display("FAIL latch_frames got=%0d want=2", frames_checked_o); end
    checks++; if (busy_cnt != BUSY_EXP2) begin failures++; $display("FAIL latch_busy_len got=%0d want=%0d", busy_cnt, BUSY_EXP2); end
    busy_before = busy_cnt;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (4) tick();
    checks++; if (busy_cnt != busy_before) begin failures++; $display("FAIL done_start_ignored got=%0d want=%0d", busy_cnt, busy_before); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL latch_done_pulse got=%0d want=1", done_cnt); end
  endtask

  task automatic test_reset_mid();
    gen_sel = 2'b00;
    inj_en = 1'b1; inj_h = 100; inj_v = 10; inj_val = 24'h00FF00;
    launch(2'b00, 8'd3);
    repeat (FR) tick();
    checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL mid_busy got=%0b want=1", busy_o); end
    checks++; if (error_count_o !== EW'(1)) begin failures++; $display("FAIL mid_err got=%0d want=1", error_count_o); end
    rst_n = 1'b0;
    #1;
    checks++; if ({busy_o, done_o, pass_o} !== 3'b000) begin failures++; $display("FAIL mid_rst_flags got=%b want=000", {busy_o, done_o, pass_o}); end
    checks++; if (error_count_o !== '0 || frames_checked_o !== 8'd0) begin failures++; $display("FAIL mid_rst_counts got=%0d/%0d want=0/0", error_count_o, frames_checked_o); end
    checks++; if ({first_err_x_o, first_err_y_o} !== 20'h0) begin failures++; $display("FAIL mid_rst_first got=%0d,%0d want=0,0", first_err_x_o, first_err_y_o); end
    tick();
    rst_n = 1'b1;
    inj_en = 1'b0;
    done_cnt = 0;
    busy_cnt = 0;
    repeat (3 * FR) tick();
    checks++; if (done_cnt != 0 || busy_cnt != 0) begin failures++; $display("FAIL mid_no_done got=%0d/%0d want=0/0", done_cnt, busy_cnt); end
  endtask

`ifdef CHECKER_CRC_EN
  task automatic test_crc();
    bit got;
    logic [15:0] exp_crc;
    exp_crc = 16'hFFFF;
    for (int y = 0; y < NV; y++)
      for (int x = 0; x < NH; x++)
        if (hl[x] < 640 && vl[y] < 480) exp_crc = crc_px(exp_crc, 24'h808080);
    gen_sel = 2'b11;
    launch(2'b11, 8'd2);
    run_until_done(4 * FR, got);
    checks++; if (crc_cnt != 2) begin failures++; $display("FAIL crc_count got=%0d want=2", crc_cnt); end
    checks++; if (crc_seen[0] !== exp_crc) begin failures++; $display("FAIL crc_f1 got=%0h want=%0h", crc_seen[0], exp_crc); end
    checks++; if (crc_seen[1] !== exp_crc) begin failures++; $display("FAIL crc_f2 got=%0h want=%0h", crc_seen[1], exp_crc); end
  endtask
`endif

  initial begin
    start_i = 1'b0; pattern_sel_i = 2'b00; num_frames_i = 8'd0;
    gen_sel = 2'b00; corrupt_all = 1'b0; inj_en = 1'b0;
    inj_h = 0; inj_v = 0; inj_val = 24'h0;
    busy_cnt = 0; done_cnt = 0; overlap_cnt = 0;
`ifdef CHECKER_CRC_EN
    crc_cnt = 0;
    for (int i = 0; i < 4; i++) crc_seen[i] = 16'h0;
`endif
    for (int i = 0; i < PD; i++) pix_pipe[i] = 24'h0;
    vif.h_count = '0; vif.v_count = '0; vif.video_active = 1'b0;
    vif.red = '0; vif.green = '0; vif.blue = '0;

    test_reset();
    test_bars_pass();
    test_single_error();
    test_blank_error();
    test_saturate();
    test_patterns();
    test_wrong_pattern();
    test_sel_latch();
    test_reset_mid();
`ifdef CHECKER_CRC_EN
    test_crc();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
